// File: rtl/vga_rect_ctrl.sv
// vga_rect_ctrl: double-buffered rectangle bounds with two round-robin write ports
module vga_rect_ctrl #(
  parameter int NRECT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_end,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_idx,
  input  logic        a_sel,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_idx,
  input  logic        b_sel,
  input  logic [31:0] b_data,
  output logic [31:0] o_vga_x0,
  output logic [31:0] o_vga_y0,
  output logic [31:0] o_vga_x1,
  output logic [31:0] o_vga_y1,
  output logic        o_busy,
  output logic [7:0]  o_commit_cnt
);
  localparam int NW = 2 * NRECT;
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] shadow_q [NW];
  logic [31:0] active_q [NW];
  logic [1:0]  k_q, k_d;
  logic        dirty_q, dirty_d;
  logic        rr_q, rr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        idle, grant_a, grant_b, wr;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  // rr_q high means B holds priority, i.e. A was granted most recently
  always_comb begin
    idle    = (state_q == IDLE) && !i_rst;
    grant_a = idle && a_valid && (!b_valid || !rr_q);
    grant_b = idle && b_valid && (!a_valid || rr_q);
    wr      = grant_a || grant_b;
    wr_addr = grant_a ? {a_idx, a_sel} : {b_idx, b_sel};
    wr_data = grant_a ? a_data : b_data;
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    rr_d    = grant_a ? 1'b1 : grant_b ? 1'b0 : rr_q;
    unique case (state_q)
      IDLE: begin
        dirty_d = dirty_q || wr;
        if (i_frame_end && (dirty_q || wr)) begin
          state_d = COPY;
          k_d     = 2'd0;
        end
      end
      COPY: begin
        k_d     = k_q + 2'd1;
        state_d = (k_q == 2'd3) ? DONE : COPY;
      end
      DONE: begin
        dirty_d = 1'b0;
        cnt_d   = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      dirty_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < NW; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dirty_q <= dirty_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (wr) shadow_q[wr_addr] <= wr_data;
      if (state_q == COPY) active_q[k_q] <= shadow_q[k_q];
    end
  end
  assign a_ready      = grant_a;
  assign b_ready      = grant_b;
  assign o_vga_x0     = active_q[0];
  assign o_vga_y0     = active_q[1];
  assign o_vga_x1     = active_q[2];
  assign o_vga_y1     = active_q[3];
  assign o_busy       = state_q != IDLE;
  assign o_commit_cnt = cnt_q;
endmodule

// File: tb/tb_vga_rect_ctrl.sv
// tb_vga_rect_ctrl: directed scenarios plus randomized traffic against a bank/countdown model
module tb_vga_rect_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fe = 1'b0;
  logic        a_valid = 1'b0, a_idx = 1'b0, a_sel = 1'b0;
  logic        b_valid = 1'b0, b_idx = 1'b0, b_sel = 1'b0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, busy;
  logic [31:0] x0, y0, x1, y1;
  logic [7:0]  ccnt;
  logic [31:0] dut_act [4];
  int nvec = 0, nerr = 0;
  logic [31:0] ms [4];
  logic [31:0] ma [4];
  bit          md, bprio;
  int          mbc;
  logic [7:0]  mc;

  vga_rect_ctrl #(.NRECT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_end(fe),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_sel(a_sel), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_sel(b_sel), .b_data(b_data),
    .o_vga_x0(x0), .o_vga_y0(y0), .o_vga_x1(x1), .o_vga_y1(y1),
    .o_busy(busy), .o_commit_cnt(ccnt)
  );

  always #5 clk = ~clk;
  assign dut_act[0] = x0;
  assign dut_act[1] = y0;
  assign dut_act[2] = x1;
  assign dut_act[3] = y1;

  function automatic bit exp_ga();
    return mbc == 0 && !rst && a_valid && (!b_valid || !bprio);
  endfunction
  function automatic bit exp_gb();
    return mbc == 0 && !rst && b_valid && (!a_valid || bprio);
  endfunction

  // Model: a commit is a 5-cycle countdown; the first four steps copy one word each
  task automatic tick();
    bit ga, gb;
    ga = exp_ga();
    gb = exp_gb();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin ms[k] = '0; ma[k] = '0; end
      md = 0; bprio = 0; mbc = 0; mc = '0;
    end else if (mbc == 0) begin
      if (ga) begin ms[{a_idx, a_sel}] = a_data; md = 1; bprio = 1; end
      if (gb) begin ms[{b_idx, b_sel}] = b_data; md = 1; bprio = 0; end
      if (fe && md) mbc = 5;
    end else begin
      if (mbc > 1) ma[5 - mbc] = ms[5 - mbc];
      else begin md = 0; mc = mc + 8'd1; end
      mbc--;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; a_valid = 1; b_valid = 1;
    #1;
    nvec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: a=%b b=%b want 0 0", a_ready, b_ready); end
    tick(); tick();
    nvec++; if ({x0, y0, x1, y1} !== 128'd0) begin nerr++; $display("FAIL reset_active: got %h want 0", {x0, y0, x1, y1}); end
    nvec++; if (busy !== 1'b0 || ccnt !== 8'd0) begin nerr++; $display("FAIL reset_status: busy=%b cnt=%0d want 0 0", busy, ccnt); end
    rst = 0; a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_single_commit();
    int nb;
    a_valid = 1; a_idx = 0; a_sel = 0; a_data = 32'h0190_0064;
    #1;
    nvec++; if (a_ready !== 1'b1) begin nerr++; $display("FAIL single_grant: a_ready=%b want 1", a_ready); end
    tick();
    a_valid = 0; fe = 1;
    tick();
    fe = 0;
    nvec++; if (busy !== 1'b1 || x0 !== 32'd0) begin nerr++; $display("FAIL single_trigger: busy=%b x0=%h want 1 0", busy, x0); end
    tick();
    nvec++; if (x0 !== 32'h0190_0064) begin nerr++; $display("FAIL single_latency: x0=%h want 01900064", x0); end
    nb = 1;
    for (int i = 0; i < 8; i++) begin
      nb += busy ? 1 : 0;
      tick();
    end
    nvec++; if (nb !== 5) begin nerr++; $display("FAIL single_busy_len: got %0d want 5", nb); end
    nvec++; if (ccnt !== 8'd1) begin nerr++; $display("FAIL single_cnt: got %0d want 1", ccnt); end
  endtask

  task automatic test_contention();
    logic [31:0] ad [2], bd [2];
    int ai = 0, bi = 0;
    rst = 1; tick(); rst = 0;
    ad[0] = 32'h0010_0001; ad[1] = 32'h0020_0002; bd[0] = 32'h0030_0003; bd[1] = 32'h0040_0004;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; {a_idx, a_sel} = 2'(ai); a_data = ad[ai];
      b_valid = 1; {b_idx, b_sel} = 2'(2 + bi); b_data = bd[bi];
      #1;
      nvec++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin nerr++; $display("FAIL contention_grant%0d: a=%b b=%b want %b %b", i, a_ready, b_ready, i % 2 == 0, i % 2 == 1); end
      if (exp_ga()) ai++;
      if (exp_gb()) bi++;
      tick();
      nvec++; if ({x0, y0, x1, y1} !== 128'd0) begin nerr++; $display("FAIL contention_active%0d: got %h want 0", i, {x0, y0, x1, y1}); end
    end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_blocked();
    fe = 1; tick(); fe = 0;
    b_valid = 1; b_idx = 0; b_sel = 0; b_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (b_ready !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL blocked_cycle%0d: b_ready=%b busy=%b want 0 1", i, b_ready, busy); end
      tick();
    end
    #1;
    nvec++; if (b_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL blocked_release: b_ready=%b busy=%b want 1 0", b_ready, busy); end
    nvec++; if ({x0, y0, x1, y1} !== {32'h0010_0001, 32'h0020_0002, 32'h0030_0003, 32'h0040_0004}) begin nerr++; $display("FAIL blocked_commit_data: got %h", {x0, y0, x1, y1}); end
    tick();
    b_valid = 0;
    tick();
    nvec++; if (x0 !== 32'h0010_0001 || ccnt !== mc) begin nerr++; $display("FAIL blocked_deferred: x0=%h cnt=%0d want 00100001 %0d", x0, ccnt, mc); end
  endtask

  task automatic test_clean_frame();
    logic [127:0] snap;
    logic [7:0]   c0;
    fe = 1; tick(); fe = 0;
    repeat (6) tick();
    nvec++; if (x0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL flush_x0: got %h want deadbeef", x0); end
    snap = {x0, y0, x1, y1}; c0 = ccnt;
    fe = 1; tick(); fe = 0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL clean_busy%0d: got %b want 0", i, busy); end
      tick();
    end
    nvec++; if (ccnt !== c0 || {x0, y0, x1, y1} !== snap) begin nerr++; $display("FAIL clean_unchanged: cnt=%0d want %0d", ccnt, c0); end
  endtask

  task automatic test_same_cycle();
    a_valid = 1; a_idx = 1; a_sel = 1; a_data = 32'h0258_01F4; fe = 1;
    #1;
    nvec++; if (a_ready !== 1'b1) begin nerr++; $display("FAIL same_grant: a_ready=%b want 1", a_ready); end
    tick();
    a_valid = 0; fe = 0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL same_trigger: busy=%b want 1", busy); end
    repeat (5) tick();
    nvec++; if (y1 !== 32'h0258_01F4 || y1 !== ma[3]) begin nerr++; $display("FAIL same_y1: got %h want 025801f4", y1); end
  endtask

  task automatic test_reset_mid_copy();
    a_valid = 1; a_idx = 0; a_sel = 1; a_data = 32'h1111_2222; fe = 1;
    tick();
    a_valid = 0; fe = 0;
    tick();
    rst = 1; a_valid = 1;
    #1;
    nvec++; if (a_ready !== 1'b0) begin nerr++; $display("FAIL midcopy_ready: got %b want 0", a_ready); end
    tick();
    rst = 0; a_valid = 0;
    #1;
    nvec++; if ({x0, y0, x1, y1} !== 128'd0 || busy !== 1'b0 || ccnt !== 8'd0) begin nerr++; $display("FAIL midcopy_clear: act=%h busy=%b cnt=%0d want 0", {x0, y0, x1, y1}, busy, ccnt); end
    a_valid = 1; a_idx = 1; a_sel = 0; a_data = 32'h1234_5678; fe = 1;
    tick();
    a_valid = 0; fe = 0;
    repeat (5) tick();
    nvec++; if (x1 !== 32'h1234_5678 || ccnt !== 8'd1 || busy !== 1'b0) begin nerr++; $display("FAIL midcopy_recommit: x1=%h cnt=%0d busy=%b want 12345678 1 0", x1, ccnt, busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1; {a_idx, a_sel} = 2'($urandom_range(0, 3)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1; {b_idx, b_sel} = 2'($urandom_range(0, 3)); b_data = $urandom;
      end
      fe = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      #1;
      nvec++; if (a_ready !== exp_ga() || b_ready !== exp_gb()) begin nerr++; $display("FAIL rand_grant@%0d: a=%b b=%b want %b %b", i, a_ready, b_ready, exp_ga(), exp_gb()); end
      nvec++; if (busy !== (mbc > 0) || ccnt !== mc) begin nerr++; $display("FAIL rand_status@%0d: busy=%b cnt=%0d want %b %0d", i, busy, ccnt, mbc > 0, mc); end
      for (int k = 0; k < 4; k++) begin
        nvec++; if (dut_act[k] !== ma[k]) begin nerr++; $display("FAIL rand_word%0d@%0d: got %h want %h", k, i, dut_act[k], ma[k]); end
      end
      if (exp_ga() || rst) a_valid = exp_ga() ? 1'b0 : a_valid;
      if (exp_gb()) b_valid = 1'b0;
      tick();
    end
    a_valid = 0; b_valid = 0; fe = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_contention();
    test_blocked();
    test_clean_frame();
    test_same_cycle();
    test_reset_mid_copy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
